// File: rtl/cpu_pkg.sv
//============================================================================
// Module   : cpu_pkg
// Desc     : Shared issue-queue and functional-unit constants and types.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package cpu_pkg;

    localparam int IQ_ENTRIES  = 16;
    localparam int IQ_IDX_W    = 4;
    localparam int NUM_FU      = 3;
    localparam int FU_MEM_PORT = 2;

    typedef logic [IQ_IDX_W-1:0] iq_idx_t;

endpackage

`default_nettype wire

// File: rtl/oldest_picker.sv
//============================================================================
// Module   : oldest_picker
// Desc     : Finds the oldest set bit of a candidate mask using an age matrix.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module oldest_picker
    import cpu_pkg::*;
#(
    parameter int NUM_ENTRIES = IQ_ENTRIES,
    parameter int IDX_W       = IQ_IDX_W
) (
    input  logic [NUM_ENTRIES-1:0]                  cand,
    input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older,
    output logic                                    found,
    output logic [IDX_W-1:0]                        idx
);

    // w_beaten[c][j]: candidate j is older than candidate c
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] w_beaten;
    logic [NUM_ENTRIES-1:0]                  w_oldest;

    for (genvar c = 0; c < NUM_ENTRIES; c++) begin : g_col
        for (genvar j = 0; j < NUM_ENTRIES; j++) begin : g_row
            assign w_beaten[c][j] = cand[j] & older[j][c];
        end
        assign w_oldest[c] = cand[c] & ~(|w_beaten[c]);
    end

    always_comb begin
        idx   = '0;
        found = |w_oldest;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_oldest[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/issue_select_arbiter.sv
//============================================================================
// Module   : issue_select_arbiter
// Desc     : Age-ordered select/grant for 16 issue-queue entries onto 3 FUs.
//            Optional counters enabled by ISSUE_ARB_PERF_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module issue_select_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_ENTRIES = IQ_ENTRIES,
    parameter int IDX_W       = IQ_IDX_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_valid,
    input  logic [IDX_W-1:0]       alloc_idx,
    input  logic                   alloc_mem,
    input  logic [NUM_ENTRIES-1:0] entry_ready,
    input  logic                   flush,
    input  logic [NUM_FU-1:0]      fu_ready,
    output logic [NUM_FU-1:0]      grant_valid,
    output logic [IDX_W-1:0]       grant_idx0,
    output logic [IDX_W-1:0]       grant_idx1,
    output logic [IDX_W-1:0]       grant_idx2,
    output logic [NUM_ENTRIES-1:0] issue_clear
`ifdef ISSUE_ARB_PERF_EN
    ,
    output logic [31:0]            perf_grant_cnt,
    output logic [31:0]            perf_block_cnt
`endif
);

    localparam logic [NUM_ENTRIES-1:0] c_one = NUM_ENTRIES'(1);

    logic [NUM_ENTRIES-1:0]                  r_valid;
    logic [NUM_ENTRIES-1:0]                  r_mem;
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_older;
    logic [NUM_FU-1:0]                       r_grant_valid;
    logic [IDX_W-1:0]                        r_grant_idx0;
    logic [IDX_W-1:0]                        r_grant_idx1;
    logic [IDX_W-1:0]                        r_grant_idx2;
    logic [NUM_ENTRIES-1:0]                  r_issue_clear;

    logic [NUM_ENTRIES-1:0]                  w_cand;
    logic [NUM_ENTRIES-1:0]                  w_cand_alu;
    logic [NUM_ENTRIES-1:0]                  w_cand1;
    logic [NUM_ENTRIES-1:0]                  w_cand2;
    logic                                    w_found0, w_found1, w_found2;
    logic [IDX_W-1:0]                        w_idx0, w_idx1, w_idx2;
    logic                                    w_pick0, w_pick1, w_pick2;
    logic [NUM_ENTRIES-1:0]                  w_mask0, w_mask1, w_mask2;
    logic [NUM_ENTRIES-1:0]                  w_clear;
    logic                                    w_alloc_ok;
    logic [NUM_ENTRIES-1:0]                  w_alloc_mask;
    logic [NUM_ENTRIES-1:0]                  w_valid_nxt;
    logic [NUM_ENTRIES-1:0]                  w_mem_nxt;
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] w_older_nxt;

    assign w_cand     = r_valid & entry_ready;
    assign w_cand_alu = w_cand & ~r_mem;

    // FU0 and FU1 take ALU ops only; FU2 (the memory port) takes anything left
    oldest_picker #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_pick0 (
        .cand  (w_cand_alu),
        .older (r_older),
        .found (w_found0),
        .idx   (w_idx0)
    );
    assign w_pick0 = w_found0 & fu_ready[0];
    assign w_mask0 = w_pick0 ? (c_one << w_idx0) : '0;
    assign w_cand1 = w_cand_alu & ~w_mask0;

    oldest_picker #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_pick1 (
        .cand  (w_cand1),
        .older (r_older),
        .found (w_found1),
        .idx   (w_idx1)
    );
    assign w_pick1 = w_found1 & fu_ready[1];
    assign w_mask1 = w_pick1 ? (c_one << w_idx1) : '0;
    assign w_cand2 = w_cand & ~w_mask0 & ~w_mask1;

    oldest_picker #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_pick2 (
        .cand  (w_cand2),
        .older (r_older),
        .found (w_found2),
        .idx   (w_idx2)
    );
    assign w_pick2 = w_found2 & fu_ready[FU_MEM_PORT];
    assign w_mask2 = w_pick2 ? (c_one << w_idx2) : '0;

    assign w_clear      = w_mask0 | w_mask1 | w_mask2;
    assign w_alloc_ok   = alloc_valid & ~r_valid[alloc_idx];
    assign w_alloc_mask = w_alloc_ok ? (c_one << alloc_idx) : '0;
    assign w_valid_nxt  = (r_valid & ~w_clear) | w_alloc_mask;
    assign w_mem_nxt    = (r_mem & ~w_alloc_mask) | (alloc_mem ? w_alloc_mask : '0);

    // New entry is younger than every live entry and older than none
    always_comb begin
        w_older_nxt = r_older;
        for (int a = 0; a < NUM_ENTRIES; a++) begin
            for (int b = 0; b < NUM_ENTRIES; b++) begin
                if (w_alloc_mask[b]) begin
                    w_older_nxt[a][b] = r_valid[a];
                end
                if (w_alloc_mask[a]) begin
                    w_older_nxt[a][b] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= '0;
            r_mem         <= '0;
            r_older       <= '0;
            r_grant_valid <= '0;
            r_grant_idx0  <= '0;
            r_grant_idx1  <= '0;
            r_grant_idx2  <= '0;
            r_issue_clear <= '0;
        end else if (flush) begin
            r_valid       <= '0;
            r_older       <= '0;
            r_grant_valid <= '0;
            r_issue_clear <= '0;
        end else begin
            r_valid       <= w_valid_nxt;
            r_mem         <= w_mem_nxt;
            r_older       <= w_older_nxt;
            r_grant_valid <= {w_pick2, w_pick1, w_pick0};
            r_issue_clear <= w_clear;
            if (w_pick0) r_grant_idx0 <= w_idx0;
            if (w_pick1) r_grant_idx1 <= w_idx1;
            if (w_pick2) r_grant_idx2 <= w_idx2;
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_idx0  = r_grant_idx0;
    assign grant_idx1  = r_grant_idx1;
    assign grant_idx2  = r_grant_idx2;
    assign issue_clear = r_issue_clear;

`ifdef ISSUE_ARB_PERF_EN
    logic [31:0] r_perf_grant_cnt;
    logic [31:0] r_perf_block_cnt;
    logic        w_blocked;

    assign w_blocked = (|w_cand) & ~(w_pick0 | w_pick1 | w_pick2);

    // Counters survive flush; only reset clears them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_grant_cnt <= '0;
            r_perf_block_cnt <= '0;
        end else begin
            r_perf_grant_cnt <= r_perf_grant_cnt + 32'($countones(r_grant_valid));
            if (w_blocked) begin
                r_perf_block_cnt <= r_perf_block_cnt + 32'd1;
            end
        end
    end

    assign perf_grant_cnt = r_perf_grant_cnt;
    assign perf_block_cnt = r_perf_block_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_select_arbiter.sv
//============================================================================
// Module   : tb_issue_select_arbiter
// Desc     : Directed self-checking bench for issue_select_arbiter
//            (perf checks compiled in with ISSUE_ARB_PERF_EN).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_issue_select_arbiter;

    logic        clk;
    logic        reset;
    logic        alloc_valid;
    logic [3:0]  alloc_idx;
    logic        alloc_mem;
    logic [15:0] entry_ready;
    logic        flush;
    logic [2:0]  fu_ready;
    logic [2:0]  grant_valid;
    logic [3:0]  grant_idx0;
    logic [3:0]  grant_idx1;
    logic [3:0]  grant_idx2;
    logic [15:0] issue_clear;
`ifdef ISSUE_ARB_PERF_EN
    logic [31:0] perf_grant_cnt;
    logic [31:0] perf_block_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    issue_select_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .alloc_mem   (alloc_mem),
        .entry_ready (entry_ready),
        .flush       (flush),
        .fu_ready    (fu_ready),
        .grant_valid (grant_valid),
        .grant_idx0  (grant_idx0),
        .grant_idx1  (grant_idx1),
        .grant_idx2  (grant_idx2),
        .issue_clear (issue_clear)
`ifdef ISSUE_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_block_cnt (perf_block_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic alloc(input logic [3:0] idx, input logic mem);
        alloc_valid = 1'b1;
        alloc_idx   = idx;
        alloc_mem   = mem;
        tick();
        alloc_valid = 1'b0;
        alloc_mem   = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        alloc_valid = 1'b0;
        alloc_idx   = '0;
        alloc_mem   = 1'b0;
        entry_ready = '0;
        flush       = 1'b0;
        fu_ready    = '0;
        tick();
        tick();
        chk("reset_gv",    32'(grant_valid), 32'h0);
        chk("reset_clr",   32'(issue_clear), 32'h0);
        chk("reset_idx0",  32'(grant_idx0),  32'h0);
        reset = 1'b0;
        tick();

        // Case 1: three ALU ops, one per FU, in age order
        alloc(4'd3, 1'b0);
        alloc(4'd7, 1'b0);
        alloc(4'd1, 1'b0);
        entry_ready = 16'hFFFF;
        fu_ready    = 3'b111;
        tick();
        chk("c1_gv",   32'(grant_valid), 32'h7);
        chk("c1_idx0", 32'(grant_idx0),  32'd3);
        chk("c1_idx1", 32'(grant_idx1),  32'd7);
        chk("c1_idx2", 32'(grant_idx2),  32'd1);
        chk("c1_clr",  32'(issue_clear), 32'h008A);
        tick();
        chk("c1_pulse_gv",  32'(grant_valid), 32'h0);
        chk("c1_pulse_clr", 32'(issue_clear), 32'h0);

        // Case 3: FUs busy, then only FU1 ready
        entry_ready = '0;
        fu_ready    = 3'b000;
        alloc(4'd4, 1'b0);
        alloc(4'd6, 1'b0);
        entry_ready = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c3_blocked_gv", 32'(grant_valid), 32'h0);
        end
        fu_ready = 3'b010;
        tick();
        chk("c3_gv_a",   32'(grant_valid), 32'h2);
        chk("c3_idx1_a", 32'(grant_idx1),  32'd4);
        chk("c3_clr_a",  32'(issue_clear), 32'h0010);
        tick();
        chk("c3_gv_b",   32'(grant_valid), 32'h2);
        chk("c3_idx1_b", 32'(grant_idx1),  32'd6);
        chk("c3_clr_b",  32'(issue_clear), 32'h0040);
        tick();
        chk("c3_gv_c",     32'(grant_valid), 32'h0);
        chk("hold_idx0",   32'(grant_idx0),  32'd3);
        chk("hold_idx2",   32'(grant_idx2),  32'd1);
`ifdef ISSUE_ARB_PERF_EN
        chk("perf_grant", perf_grant_cnt, 32'd5);
        chk("perf_block", perf_block_cnt, 32'd3);
`endif

        // Case 2: mem op can only go to FU2
        entry_ready = '0;
        fu_ready    = 3'b111;
        alloc(4'd5, 1'b1);
        alloc(4'd2, 1'b0);
        entry_ready = 16'hFFFF;
        tick();
        chk("c2_gv",   32'(grant_valid), 32'h5);
        chk("c2_idx0", 32'(grant_idx0),  32'd2);
        chk("c2_idx2", 32'(grant_idx2),  32'd5);
        chk("c2_clr",  32'(issue_clear), 32'h0024);
        tick();
        chk("c2_pulse_gv", 32'(grant_valid), 32'h0);

        // Case 4: full queue, single ready entry
        entry_ready = '0;
        for (int i = 0; i < 16; i++) begin
            alloc(4'(i), 1'b0);
        end
        entry_ready = 16'h0200;
        tick();
        chk("c4_gv",   32'(grant_valid), 32'h1);
        chk("c4_idx0", 32'(grant_idx0),  32'd9);
        chk("c4_clr",  32'(issue_clear), 32'h0200);
        tick();
        chk("c4_no_regrant_a", 32'(grant_valid), 32'h0);
        tick();
        chk("c4_no_regrant_b", 32'(grant_valid), 32'h0);
        // Re-alloc of a live ALU entry as mem must be ignored
        entry_ready = '0;
        alloc(4'd12, 1'b1);
        entry_ready = 16'h1000;
        fu_ready    = 3'b001;
        tick();
        chk("c4_dup_gv",   32'(grant_valid), 32'h1);
        chk("c4_dup_idx0", 32'(grant_idx0),  32'd12);
        entry_ready = 16'h0C00;
        fu_ready    = 3'b111;
        tick();
        chk("c4_age_gv",   32'(grant_valid), 32'h3);
        chk("c4_age_idx0", 32'(grant_idx0),  32'd10);
        chk("c4_age_idx1", 32'(grant_idx1),  32'd11);
        chk("c4_age_clr",  32'(issue_clear), 32'h0C00);
        entry_ready = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Case 5: flush in the pick cycle kills the grant
        alloc(4'd8, 1'b0);
        alloc(4'd10, 1'b0);
        entry_ready = 16'hFFFF;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("c5_flush_gv",  32'(grant_valid), 32'h0);
        chk("c5_flush_clr", 32'(issue_clear), 32'h0);
        tick();
        chk("c5_after_gv",  32'(grant_valid), 32'h0);
        alloc(4'd8, 1'b0);
        tick();
        chk("c5_realloc_gv",   32'(grant_valid), 32'h1);
        chk("c5_realloc_idx0", 32'(grant_idx0),  32'd8);
        tick();

        // Flush overrides a same-cycle alloc
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_idx   = 4'd3;
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        tick();
        chk("flush_alloc_gv_a", 32'(grant_valid), 32'h0);
        tick();
        chk("flush_alloc_gv_b", 32'(grant_valid), 32'h0);

        // Async reset mid-operation drops the live grant and a pending pick
        entry_ready = '0;
        fu_ready    = 3'b001;
        alloc(4'd6, 1'b0);
        alloc(4'd7, 1'b0);
        entry_ready = 16'hFFFF;
        tick();
        chk("mr_gv_pre",   32'(grant_valid), 32'h1);
        chk("mr_idx0_pre", 32'(grant_idx0),  32'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_gv_async",   32'(grant_valid), 32'h0);
        chk("mr_idx0_async", 32'(grant_idx0),  32'h0);
        chk("mr_clr_async",  32'(issue_clear), 32'h0);
        #1;
        reset = 1'b0;
        tick();
        chk("mr_gv_post", 32'(grant_valid), 32'h0);
        tick();
        chk("mr_gv_post2", 32'(grant_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/issue_select_arbiter.md
Name: issue_select_arbiter

Overview:
- Select/grant scheduler for the issue queue's 16 entries.
- Tracks allocation age and picks the oldest operand-ready entries each cycle.
- Grants at most one entry per functional unit (FU0, FU1, FU2) and pulses a clear back to the queue.
- Sits between issue-queue entry storage and the three execute units; the queue drives issued_funct_unitN from the granted index.

Parameters:
- NUM_ENTRIES, 16, issue-queue depth (entry count)
- IDX_W, 4, entry index width, equal to log2(NUM_ENTRIES)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- alloc_valid  in  1  an entry is written into the queue this cycle
- alloc_idx  in  IDX_W  index of the written entry
- alloc_mem  in  1  written entry is a load/store; it may issue only to FU2
- entry_ready  in  NUM_ENTRIES  per-entry all-operands-ready, from queue wakeup logic
- flush  in  1  mispredict flush; discards all tracked entries
- fu_ready  in  3  FU k can accept an instruction this cycle
- grant_valid  out  3  FU k is granted an entry this cycle (registered)
- grant_idx0  out  IDX_W  entry granted to FU0
- grant_idx1  out  IDX_W  entry granted to FU1
- grant_idx2  out  IDX_W  entry granted to FU2
- issue_clear  out  NUM_ENTRIES  one-hot-per-grant pulse; queue frees these entries

Behaviour:
- State:
  - valid[NUM_ENTRIES]
  - mem[NUM_ENTRIES]
  - age matrix older[a][b]: 1 means a was allocated before b
- Reset (async): valid, older, grant_valid, grant_idx*, issue_clear all 0.
- Alloc at edge with alloc_valid=1:
  - valid[i]=1, mem[i]=alloc_mem.
  - older[j][i]=1 for every currently valid j; older[i][*]=0.
  - Alloc to an already-valid index is ignored; no state change.
- Candidates: cand = valid & entry_ready.
  - Oldest candidate c = the candidate with no other candidate j where older[j][c]=1.
- Pick order, combinational, same cycle:
  - FU0: oldest non-mem candidate, only if fu_ready[0].
  - FU1: oldest non-mem candidate excluding FU0's pick, only if fu_ready[1].
  - FU2: oldest candidate of any type excluding FU0/FU1 picks, only if fu_ready[2].
- Latency: picks register at the edge. grant_valid, grant_idx* and issue_clear are valid the following cycle and last one cycle.
  - valid[picked] clears at that same edge, so an entry is never granted twice.
- grant_idxk holds its last value when grant_valid[k]=0; consumers must qualify with grant_valid.
- Entry that is ready but not picked (FU busy or older entries win) stays valid and is retried every cycle.
- Full/empty: no candidates means all grant_valid=0. All 16 valid with 0 ready is legal; fullness is reported by the queue, not here.
- Flush at edge:
  - valid and older cleared; grant_valid and issue_clear forced to 0 next cycle.
  - Flush overrides alloc in the same cycle.
- Alloc and grant in the same cycle always target different indices; both take effect.
- Reset mid-operation: all state is discarded immediately and no pending grant survives.

Optional Feature:
- Macro: ISSUE_ARB_PERF_EN.
- Defined: adds outputs perf_grant_cnt[31:0] and perf_block_cnt[31:0].
  - perf_grant_cnt adds popcount(grant_valid) per cycle.
  - perf_block_cnt increments each cycle in which at least one candidate exists but no grant was picked.
  - Both counters wrap at 2^32 and reset to 0; flush does not clear them.
- Undefined: ports absent, no counters synthesized.

Decomposition:
- Shared package cpu_pkg holds:
  - IQ_ENTRIES=16 and IQ_IDX_W=4
  - NUM_FU=3
  - typedef iq_idx_t
  - FU_MEM_PORT=2 constant
- Sub-module oldest_picker(cand, older) outputs found and an index, used by all three picks. FU1 and FU2 receive candidate masks with earlier picks removed.

Test Plan:
- Alloc idx 3, 7, 1 (in that order), all non-mem, entry_ready=all ones, fu_ready=3'b111 -> next cycle grant FU0=3, FU1=7, FU2=1, issue_clear=16'h008A.
- Alloc idx 5 (mem) then idx 2 (non-mem), both ready, fu_ready=3'b111 -> grant FU0=2, FU2=5, grant_valid=3'b101.
- Alloc 4, 6, both ready, fu_ready=3'b000 for 3 cycles, then 3'b010 -> no grants while blocked, then FU1=4 only; next cycle FU1=6.
- Alloc 0..15 all valid, entry_ready only bit 9 -> single grant FU0=9; entry 9 is never granted again.
- Alloc 8 and 10 ready, flush asserted the same cycle as pick -> grant_valid=0 next cycle; a new alloc of 8 is later granted normally.
- ISSUE_ARB_PERF_EN defined, run case 1 then case 3 -> perf_grant_cnt=5, perf_block_cnt=3.
